// File: rtl/fp_mult_seq.sv
// Sequential single-precision multiplier front end: sign/exponent plus a raw 48-bit
// mantissa product built by radix-2^BITS_PER_CYCLE shift-add, with valid/ready on both sides.
module fp_mult_seq #(
    parameter int unsigned BITS_PER_CYCLE = 2
) (
    input  logic        clk,
    input  logic        clr_b,
    input  logic [31:0] A_in,
    input  logic [31:0] B_in,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        S_out,
    output logic [7:0]  E_out,
    output logic [47:0] P_out,
    output logic        out_valid,
    input  logic        out_ready
);
    localparam int unsigned N_ITER = 24 / BITS_PER_CYCLE;
    localparam int unsigned CW     = (N_ITER > 1) ? $clog2(N_ITER) : 1;

    typedef enum logic [1:0] {IDLE, MULT, DONE} state_t;

    state_t                    state;
    logic                      s_r;
    logic [7:0]                e_r;
    logic [47:0]               mcand;
    logic [23:0]               mplier;
    logic [47:0]               acc;
    logic [CW-1:0]             cnt;

    logic                      zero_op;
    logic [7:0]                e_sum;
    logic [BITS_PER_CYCLE-1:0] digit;
    logic [47:0]               acc_nxt;
    logic                      last;

    assign in_ready = (state == IDLE);
    assign zero_op  = (A_in[30:23] == 8'd0) || (B_in[30:23] == 8'd0);
    assign e_sum    = A_in[30:23] + B_in[30:23] - 8'd127;
    assign digit    = mplier[BITS_PER_CYCLE-1:0];
    assign acc_nxt  = acc + mcand * 48'(digit);
    assign last     = (cnt == CW'(N_ITER - 1));

    always_ff @(posedge clk or negedge clr_b) begin
        if (!clr_b) begin
            state     <= IDLE;
            s_r       <= 1'b0;
            e_r       <= 8'd0;
            mcand     <= 48'd0;
            mplier    <= 24'd0;
            acc       <= 48'd0;
            cnt       <= '0;
            S_out     <= 1'b0;
            E_out     <= 8'd0;
            P_out     <= 48'd0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    s_r    <= A_in[31] ^ B_in[31];
                    // Zero operands still walk through MULT; a null multiplicand keeps the product 0.
                    e_r    <= zero_op ? 8'd0  : e_sum;
                    mcand  <= zero_op ? 48'd0 : {24'd0, 1'b1, A_in[22:0]};
                    mplier <= {1'b1, B_in[22:0]};
                    acc    <= 48'd0;
                    cnt    <= '0;
                    state  <= MULT;
                end
                MULT: begin
                    acc    <= acc_nxt;
                    mcand  <= mcand << BITS_PER_CYCLE;
                    mplier <= mplier >> BITS_PER_CYCLE;
                    cnt    <= cnt + CW'(1);
                    if (last) begin
                        S_out     <= s_r;
                        E_out     <= e_r;
                        P_out     <= acc_nxt;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: if (out_ready) begin
                    out_valid <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fp_mult_seq.sv
// Scoreboard bench for fp_mult_seq: directed products, zero flush, backpressure,
// mid-operation reset and random operands against a direct-multiply reference.
module tb_fp_mult_seq;
    localparam int BPC = 2;
    localparam int LAT = 24 / BPC + 1;

    logic        clk = 1'b0;
    logic        clr_b;
    logic [31:0] A_in, B_in;
    logic        in_valid, in_ready;
    logic        S_out, out_valid, out_ready;
    logic [7:0]  E_out;
    logic [47:0] P_out;

    typedef struct packed {
        logic        s;
        logic [7:0]  e;
        logic [47:0] p;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_fail = 0;

    fp_mult_seq #(.BITS_PER_CYCLE(BPC)) dut (
        .clk(clk), .clr_b(clr_b), .A_in(A_in), .B_in(B_in),
        .in_valid(in_valid), .in_ready(in_ready),
        .S_out(S_out), .E_out(E_out), .P_out(P_out),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
        exp_t r;
        logic [47:0] ma, mb;
        r.s = a[31] ^ b[31];
        if (a[30:23] == 8'd0 || b[30:23] == 8'd0) begin
            r.e = 8'd0;
            r.p = 48'd0;
        end else begin
            ma  = {24'd0, 1'b1, a[22:0]};
            mb  = {24'd0, 1'b1, b[22:0]};
            r.e = a[30:23] + b[30:23] - 8'd127;
            r.p = ma * mb;
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one operation, check latency and result, optionally stall the output for `hold` cycles.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input exp_t e, input int hold);
        int   lat;
        exp_t got;
        lat = 0;
        while (!in_ready && lat < 50) begin tick(); lat++; end
        chk("in_ready_idle", 64'(in_ready), 64'd1);
        sb.push_back(e);
        A_in = a; B_in = b; in_valid = 1'b1;
        out_ready = (hold == 0);
        tick();
        in_valid = 1'b0;
        lat = 1;
        chk("in_ready_busy", 64'(in_ready), 64'd0);
        while (!out_valid && lat < 40) begin tick(); lat++; end
        chk("latency", 64'(lat), 64'(LAT));
        chk("sb_nonempty", 64'(sb.size() > 0), 64'd1);
        if (out_valid && sb.size() > 0) begin
            got = sb.pop_front();
            chk("S_out", 64'(S_out), 64'(got.s));
            chk("E_out", 64'(E_out), 64'(got.e));
            chk("P_out", 64'(P_out), 64'(got.p));
            for (int i = 0; i < hold; i++) begin
                in_valid = 1'b1;
                A_in = $urandom; B_in = $urandom;
                tick();
                chk("hold_valid", 64'(out_valid), 64'd1);
                chk("hold_ready", 64'(in_ready), 64'd0);
                chk("hold_P", 64'(P_out), 64'(got.p));
                chk("hold_E", 64'(E_out), 64'(got.e));
            end
            in_valid = 1'b0;
            out_ready = 1'b1;
            tick();
            chk("drain_valid", 64'(out_valid), 64'd0);
            chk("drain_ready", 64'(in_ready), 64'd1);
        end
    endtask

    initial begin
        logic [31:0] ra, rb;
        clr_b = 1'b0; A_in = '0; B_in = '0; in_valid = 1'b0; out_ready = 1'b1;
        #12;
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_ready", 64'(in_ready), 64'd1);
        chk("rst_S", 64'(S_out), 64'd0);
        chk("rst_E", 64'(E_out), 64'd0);
        chk("rst_P", 64'(P_out), 64'd0);
        @(negedge clk);
        clr_b = 1'b1;

        run_op(32'h3FC00000, 32'h3FC00000, '{1'b0, 8'h7F, 48'h900000000000}, 0);
        run_op(32'h40000000, 32'h40400000, '{1'b0, 8'h81, 48'h600000000000}, 0);
        run_op(32'hBF800000, 32'h3F800000, '{1'b1, 8'h7F, 48'h400000000000}, 0);
        run_op(32'h80000000, 32'h40400000, '{1'b1, 8'h00, 48'h000000000000}, 0);
        run_op(32'h40000000, 32'h40400000, '{1'b0, 8'h81, 48'h600000000000}, 5);
        // All-ones mantissas: (2^24-1)^2
        run_op(32'h3FFFFFFF, 32'hBFFFFFFF, '{1'b1, 8'h7F, 48'hFFFFFE000001}, 0);

        // Abort during MULT, then confirm a clean operation afterwards.
        tick();
        A_in = 32'h40400000; B_in = 32'h40400000; in_valid = 1'b1;
        sb.push_back(model(A_in, B_in));
        tick();
        in_valid = 1'b0;
        repeat (4) tick();
        clr_b = 1'b0;
        #1;
        chk("abort_valid", 64'(out_valid), 64'd0);
        chk("abort_ready", 64'(in_ready), 64'd1);
        sb.delete();
        @(negedge clk);
        clr_b = 1'b1;
        run_op(32'h3FC00000, 32'h3FC00000, '{1'b0, 8'h7F, 48'h900000000000}, 0);

        for (int k = 0; k < 8; k++) begin
            ra = $urandom; rb = $urandom;
            if (k == 3) ra[30:23] = 8'd0;
            run_op(ra, rb, model(ra, rb), k % 3);
        end

        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
